// File: rtl/hdu_sb_v.sv
// Hazard-control unit for the 5-stage pipeline: operand forwarding, load-use stall,
// multi-cycle EX hold, branch flush and saturating stall/flush performance counters.
module hdu_sb_v #(
  parameter int REG_AW = 5,
  parameter int LAT_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] idex_rs1,
  input  logic [REG_AW-1:0] idex_rs2,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_memRead,
  input  logic              idex_mc_start,
  input  logic [LAT_W-1:0]  idex_mc_lat,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              exmem_regWrite,
  input  logic              memwb_regWrite,
  input  logic              ex_branch_taken,
  output logic [1:0]        forwA,
  output logic [1:0]        forwB,
  output logic              hold_front,
  output logic              hold_ex,
  output logic              bubble_ex,
  output logic              bubble_mem,
  output logic              flush_ifid,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [LAT_W-1:0] mc_cnt;
  logic             mc_idle;
  logic             mc_load;
  logic             mc_hold;
  logic             load_use;
  logic             exmem_valid;
  logic             memwb_valid;

  // Writers to x0 never produce a value worth forwarding.
  assign exmem_valid = exmem_regWrite && (exmem_rd != '0);
  assign memwb_valid = memwb_regWrite && (memwb_rd != '0);

  assign forwA = (exmem_valid && exmem_rd == idex_rs1) ? 2'b01 :
                 (memwb_valid && memwb_rd == idex_rs1) ? 2'b10 : 2'b00;
  assign forwB = (exmem_valid && exmem_rd == idex_rs2) ? 2'b01 :
                 (memwb_valid && memwb_rd == idex_rs2) ? 2'b10 : 2'b00;

  assign load_use = idex_memRead && (idex_rd != '0) &&
                    ((id_use_rs1 && idex_rd == id_rs1) ||
                     (id_use_rs2 && idex_rd == id_rs2));

  // The counter holds the remaining occupancy minus one, so the last EX cycle is hold-free.
  assign mc_idle = (mc_cnt == '0);
  assign mc_load = mc_idle && idex_mc_start && (idex_mc_lat >= LAT_W'(2));
  assign mc_hold = mc_idle ? mc_load : (mc_cnt >= LAT_W'(2));
  assign mc_busy = !mc_idle;

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    hold_front = 1'b0;
    hold_ex    = 1'b0;
    bubble_ex  = 1'b0;
    bubble_mem = 1'b0;
    flush_ifid = 1'b0;
    if (mc_hold) begin
      hold_front = 1'b1;
      hold_ex    = 1'b1;
      bubble_mem = 1'b1;
    end else if (ex_branch_taken) begin
      // The ID instruction is wrong-path, so any load-use match against it is moot.
      flush_ifid = 1'b1;
      bubble_ex  = 1'b1;
    end else if (load_use) begin
      hold_front = 1'b1;
      bubble_ex  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_cnt    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mc_load)
        mc_cnt <= idex_mc_lat - LAT_W'(1);
      else if (!mc_idle)
        mc_cnt <= mc_cnt - LAT_W'(1);

      if (hold_front && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ifid && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hdu_sb_v.md
# hdu_sb_v

Parametrised hazard-control unit for the 5-stage pipeline, the successor of the combinational forwarding/load-use unit. It adds register-zero qualification, per-operand use flags, branch-flush generation, a latency counter for multi-cycle EX operations (mul/div), and saturating stall/flush performance counters. It sits beside the pipeline registers and drives the forwarding muxes plus the hold/bubble controls of PC, IF/ID, ID/EX and EX/MEM.

## Interface
- REG_AW, 5, register-address width
- LAT_W, 4, width of multi-cycle latency field (latency 0..2^LAT_W-1)
- CNT_W, 16, width of each performance counter

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- id_rs1, id_rs2  input  REG_AW  source registers of instruction in ID
- id_use_rs1, id_use_rs2  input  1  instruction in ID actually reads rs1/rs2
- idex_rs1, idex_rs2, idex_rd  input  REG_AW  ID/EX register fields
- idex_memRead  input  1  instruction in EX is a load
- idex_mc_start  input  1  instruction in EX is a multi-cycle op
- idex_mc_lat  input  LAT_W  total EX-occupancy cycles of that op
- exmem_rd, memwb_rd  input  REG_AW  destination registers in MEM/WB
- exmem_regWrite, memwb_regWrite  input  1  write enables in MEM/WB
- ex_branch_taken  input  1  taken branch/jump resolved in EX this cycle
- forwA, forwB  output  2  00 regfile, 01 EX/MEM, 10 MEM/WB
- hold_front  output  1  hold PC and IF/ID
- hold_ex  output  1  hold ID/EX
- bubble_ex  output  1  load bubble into ID/EX
- bubble_mem  output  1  load bubble into EX/MEM
- flush_ifid  output  1  squash IF/ID
- mc_busy  output  1  multi-cycle counter non-zero
- stall_cnt  output  CNT_W  cycles with hold_front=1, saturating
- flush_cnt  output  CNT_W  branch-flush events, saturating

## Operation
- Forwarding (combinational, per operand): EX/MEM match (regWrite, rd≠0, rd==idex_rsX) → 01; else MEM/WB match → 10; else 00. EX/MEM has priority.
- Load-use hazard: idex_memRead && idex_rd≠0 && ((id_use_rs1 && idex_rd==id_rs1) || (id_use_rs2 && idex_rd==id_rs2)) → hold_front=1, bubble_ex=1.
- Multi-cycle hold: register mc_cnt (LAT_W bits).
  - mc_hold = (mc_cnt==0) ? (idex_mc_start && idex_mc_lat≥2) : (mc_cnt≥2).
  - mc_cnt==0 && idex_mc_start && idex_mc_lat≥2 → mc_cnt ← idex_mc_lat−1; mc_cnt≠0 → decrement; idex_mc_start ignored while mc_cnt≠0.
  - mc_hold → hold_front=1, hold_ex=1, bubble_mem=1; bubble_ex=0.
  - Latency 0 or 1: no hold, counter not loaded.
- Branch flush: ex_branch_taken → flush_ifid=1, bubble_ex=1, hold_front=0.
- Priority: mc_hold > ex_branch_taken > load-use. mc_hold suppresses flush and load-use outputs; a taken branch cancels a simultaneous load-use stall (the ID instruction is wrong-path).
- Forwarding is evaluated every cycle, including during holds.
- stall_cnt increments on every cycle with hold_front=1; flush_cnt on every cycle with flush_ifid=1; both hold at all-ones.

## Timing
- Reset (async, immediate): mc_cnt=0, stall_cnt=0, flush_cnt=0, mc_busy=0. Control outputs are then purely combinational from inputs with mc_cnt=0.
- All control outputs combinational, same cycle as inputs; counters update on the rising edge.
- Multi-cycle op of latency L≥2 occupies EX for exactly L cycles: mc_hold high for cycles 0..L−2 after it enters EX, low in cycle L−1; the next instruction enters EX in cycle L.
- mc_busy=1 from the edge after the start cycle until the counter returns to 0 (L−1 cycles).
- Reset asserted mid-operation clears mc_cnt; hold releases in the same cycle.

## Test plan
- Forward priority: exmem_rd=memwb_rd=idex_rs1=5, both regWrite=1 → forwA=01; exmem_regWrite=0 → forwA=10; all rd=0 → forwA=00.
- Load-use: idex_memRead=1, idex_rd=7, id_rs2=7, id_use_rs2=1 → hold_front=1, bubble_ex=1, stall_cnt +1; id_use_rs2=0 or idex_rd=0 → no stall.
- Multi-cycle L=4: start at cycle 0 → hold_ex/hold_front/bubble_mem high cycles 0–2, low cycle 3; mc_busy high cycles 1–3; stall_cnt +3. L=1 → no hold.
- Branch vs load-use: ex_branch_taken=1 with active load-use match → flush_ifid=1, bubble_ex=1, hold_front=0, flush_cnt +1.
- Reset mid-op: L=8, assert rst in cycle 2 → mc_busy=0, hold_ex=0 immediately, counters 0.
- Saturation: preload by 2^CNT_W+2 hold cycles (CNT_W=4 build) → stall_cnt=15 and stays 15.
